// File: rtl/mips_reg_writeback_if.sv
// ============================================================================
// Module      : mips_reg_writeback_if
// Description : Producer / register-file-side bundle for mips_reg_writeback.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mips_reg_writeback_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic                   alu_valid;
  logic [ADDR_W-1:0]      alu_reg;
  logic [DATA_W-1:0]      alu_data;
  logic                   alu_ready;
  logic                   mem_valid;
  logic [ADDR_W-1:0]      mem_reg;
  logic [DATA_W-1:0]      mem_data;
  logic                   mem_ready;
  logic [ADDR_W-1:0]      write_reg;
  logic [DATA_W-1:0]      write_data;
  logic                   signal_reg_write;
  logic [2**ADDR_W-1:0]   busy_mask;
  logic                   q_empty;
  logic                   q_full;

  modport master (
    output alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data,
    input  alu_ready, mem_ready, write_reg, write_data, signal_reg_write,
           busy_mask, q_empty, q_full
  );

  modport slave (
    input  alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data,
    output alu_ready, mem_ready, write_reg, write_data, signal_reg_write,
           busy_mask, q_empty, q_full
  );
endinterface

`default_nettype wire

// File: rtl/mips_reg_writeback.sv
// ============================================================================
// Module      : mips_reg_writeback
// Description : In-order write-back queue merging ALU and load results into the
//               single register-file write port. Define MIPS_WB_BYPASS_EN to
//               let a lone result skip the empty queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_reg_writeback #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  wire logic          clk,
  input  wire logic          reset,
  mips_reg_writeback_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NREG  = 2**ADDR_W;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] r_q_reg  [DEPTH];
  logic [DATA_W-1:0] r_q_data [DEPTH];
  logic [CNT_W-1:0]  r_count;
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_reg;
  logic [DATA_W-1:0] r_wr_data;

  logic              w_mem_nz;
  logic              w_alu_nz;
  logic              w_mem_ready;
  logic              w_alu_room;
  logic              w_alu_ready;
  logic              w_mem_push;
  logic              w_alu_push;
  logic              w_pop;
  logic              w_empty;
  logic              w_bypass;
  logic              w_enq_first;
  logic              w_enq_second;
  logic [ADDR_W-1:0] w_first_reg;
  logic [DATA_W-1:0] w_first_data;
  logic [PTR_W-1:0]  w_second_ptr;
  logic [NREG-1:0]   w_busy;

  assign w_mem_nz = (bus.mem_reg != '0);
  assign w_alu_nz = (bus.alu_reg != '0);
  assign w_empty  = (r_count == '0);
  assign w_pop    = ~w_empty;

  // Slots are judged on the start-of-cycle count; the pop this edge is not credited.
  assign w_mem_ready = ~w_mem_nz | (r_count < C_DEPTH);
  assign w_alu_room  = ({1'b0, r_count} + {{CNT_W{1'b0}}, bus.mem_valid & w_mem_nz})
                       < {1'b0, C_DEPTH};
  assign w_alu_ready = ~w_alu_nz | w_alu_room;

  assign w_mem_push = bus.mem_valid & w_mem_ready & w_mem_nz;
  assign w_alu_push = bus.alu_valid & w_alu_ready & w_alu_nz;

`ifdef MIPS_WB_BYPASS_EN
  assign w_bypass = w_empty & (w_mem_push | w_alu_push);
`else
  assign w_bypass = 1'b0;
`endif

  // The older of the pushes (mem wins) is "first"; a second push is always the alu.
  assign w_first_reg  = w_mem_push ? bus.mem_reg  : bus.alu_reg;
  assign w_first_data = w_mem_push ? bus.mem_data : bus.alu_data;
  assign w_enq_first  = (w_mem_push | w_alu_push) & ~w_bypass;
  assign w_enq_second = w_mem_push & w_alu_push;
  assign w_second_ptr = r_wptr + PTR_W'(w_enq_first);

  always_ff @(posedge clk) begin
    if (w_enq_first) begin
      r_q_reg[r_wptr]  <= w_first_reg;
      r_q_data[r_wptr] <= w_first_data;
    end
    if (w_enq_second) begin
      r_q_reg[w_second_ptr]  <= bus.alu_reg;
      r_q_data[w_second_ptr] <= bus.alu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count   <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_wr_en   <= 1'b0;
      r_wr_reg  <= '0;
      r_wr_data <= '0;
    end else begin
      r_count <= r_count + CNT_W'(w_enq_first) + CNT_W'(w_enq_second) - CNT_W'(w_pop);
      r_wptr  <= r_wptr + PTR_W'(w_enq_first) + PTR_W'(w_enq_second);
      r_rptr  <= r_rptr + PTR_W'(w_pop);
      if (w_pop) begin
        r_wr_en   <= 1'b1;
        r_wr_reg  <= r_q_reg[r_rptr];
        r_wr_data <= r_q_data[r_rptr];
      end else if (w_bypass) begin
        r_wr_en   <= 1'b1;
        r_wr_reg  <= w_first_reg;
        r_wr_data <= w_first_data;
      end else begin
        r_wr_en <= 1'b0;
      end
    end
  end

  always_comb begin
    w_busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < r_count) begin
        w_busy[r_q_reg[r_rptr + PTR_W'(i)]] = 1'b1;
      end
    end
    if (r_wr_en) begin
      w_busy[r_wr_reg] = 1'b1;
    end
  end

  assign bus.mem_ready        = w_mem_ready;
  assign bus.alu_ready        = w_alu_ready;
  assign bus.write_reg        = r_wr_reg;
  assign bus.write_data       = r_wr_data;
  assign bus.signal_reg_write = r_wr_en;
  assign bus.busy_mask        = w_busy;
  assign bus.q_empty          = w_empty;
  assign bus.q_full           = (r_count == C_DEPTH);

endmodule

`default_nettype wire

// File: tb/tb_mips_reg_writeback.sv
// ============================================================================
// Module      : tb_mips_reg_writeback
// Description : Self-checking bench for mips_reg_writeback against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_reg_writeback;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int NREG   = 32;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mips_reg_writeback_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mips_reg_writeback #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model: pending writes in acceptance order plus the output stage.
  logic [ADDR_W-1:0] m_reg  [$];
  logic [DATA_W-1:0] m_data [$];
  logic              m_wen   = 1'b0;
  logic [ADDR_W-1:0] m_wreg  = '0;
  logic [DATA_W-1:0] m_wdata = '0;

  function automatic bit m_mem_ready();
    return (bus.mem_reg == 0) || (m_reg.size() < DEPTH);
  endfunction

  function automatic bit m_alu_ready();
    int pend;
    pend = (bus.mem_valid && bus.mem_reg != 0) ? 1 : 0;
    return (bus.alu_reg == 0) || (m_reg.size() + pend < DEPTH);
  endfunction

  function automatic logic [NREG-1:0] m_busy();
    logic [NREG-1:0] b;
    b = '0;
    foreach (m_reg[i]) b[m_reg[i]] = 1'b1;
    if (m_wen) b[m_wreg] = 1'b1;
    return b;
  endfunction

  task automatic cycle();
    logic [ADDR_W-1:0] pr [$];
    logic [DATA_W-1:0] pd [$];
    int n0;
    bit rst_now;
    rst_now = reset;
    if (bus.mem_valid && bus.mem_reg != 0 && m_mem_ready()) begin
      pr.push_back(bus.mem_reg); pd.push_back(bus.mem_data);
    end
    if (bus.alu_valid && bus.alu_reg != 0 && m_alu_ready()) begin
      pr.push_back(bus.alu_reg); pd.push_back(bus.alu_data);
    end
    @(posedge clk);
    #1;
    if (rst_now) begin
      m_reg.delete(); m_data.delete();
      m_wen = 1'b0; m_wreg = '0; m_wdata = '0;
    end else begin
      n0 = m_reg.size();
      if (n0 > 0) begin
        m_wen = 1'b1; m_wreg = m_reg.pop_front(); m_wdata = m_data.pop_front();
      end else begin
        m_wen = 1'b0;
      end
`ifdef MIPS_WB_BYPASS_EN
      if (n0 == 0 && pr.size() > 0) begin
        m_wen = 1'b1; m_wreg = pr.pop_front(); m_wdata = pd.pop_front();
      end
`endif
      foreach (pr[i]) begin
        m_reg.push_back(pr[i]); m_data.push_back(pd[i]);
      end
    end
  endtask

  task automatic idle();
    bus.alu_valid = 1'b0;
    bus.mem_valid = 1'b0;
  endtask

  task automatic drain();
    idle();
    repeat (DEPTH + 3) cycle();
  endtask

  // Pushes mem+alu pairs (regs 8..13) until DEPTH-1 entries sit in the queue.
  task automatic fill_to_almost_full();
    int g;
    g = 0;
    while (m_reg.size() != DEPTH - 1 && g < 20) begin
      bus.mem_valid = 1'b1; bus.mem_reg = ADDR_W'(8 + 2*g); bus.mem_data = $urandom;
      bus.alu_valid = 1'b1; bus.alu_reg = ADDR_W'(9 + 2*g); bus.alu_data = $urandom;
      #1;
      cycle();
      g++;
    end
    idle();
    checks++;
    if (m_reg.size() != DEPTH - 1) begin
      failures++;
      $display("FAIL fill_bound got=%0d exp=%0d", m_reg.size(), DEPTH - 1);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    cycle();
    cycle();
    reset = 1'b0;
    checks++;
    if (bus.signal_reg_write !== 1'b0) begin
      failures++; $display("FAIL reset_wen got=%b exp=0", bus.signal_reg_write);
    end
    checks++;
    if (bus.write_reg !== '0 || bus.write_data !== '0) begin
      failures++; $display("FAIL reset_wdata got=%0d/%h exp=0/0", bus.write_reg, bus.write_data);
    end
    checks++;
    if (bus.busy_mask !== '0) begin
      failures++; $display("FAIL reset_busy got=%h exp=0", bus.busy_mask);
    end
    checks++;
    if (bus.q_empty !== 1'b1 || bus.q_full !== 1'b0) begin
      failures++; $display("FAIL reset_flags got=%b%b exp=10", bus.q_empty, bus.q_full);
    end
  endtask

  task automatic test_single_alu();
    drain();
    bus.alu_valid = 1'b1; bus.alu_reg = 5; bus.alu_data = 32'h0000_1234;
    #1;
    checks++;
    if (bus.alu_ready !== 1'b1) begin
      failures++; $display("FAIL single_ready got=%b exp=1", bus.alu_ready);
    end
    cycle();
    idle();
    checks++;
    if (bus.busy_mask[5] !== 1'b1) begin
      failures++; $display("FAIL single_busy_accept got=%b exp=1", bus.busy_mask[5]);
    end
`ifndef MIPS_WB_BYPASS_EN
    checks++;
    if (bus.signal_reg_write !== 1'b0) begin
      failures++; $display("FAIL single_early_wen got=%b exp=0", bus.signal_reg_write);
    end
    cycle();
`endif
    checks++;
    if (bus.signal_reg_write !== 1'b1 || bus.write_reg !== 5 || bus.write_data !== 32'h1234) begin
      failures++;
      $display("FAIL single_write got=%b/%0d/%h exp=1/5/00001234",
               bus.signal_reg_write, bus.write_reg, bus.write_data);
    end
    checks++;
    if (bus.busy_mask[5] !== 1'b1) begin
      failures++; $display("FAIL single_busy_out got=%b exp=1", bus.busy_mask[5]);
    end
    cycle();
    checks++;
    if (bus.signal_reg_write !== 1'b0 || bus.busy_mask !== '0) begin
      failures++;
      $display("FAIL single_after got=%b/%h exp=0/0", bus.signal_reg_write, bus.busy_mask);
    end
  endtask

  task automatic test_priority();
    int pos3, pos4;
    drain();
    fill_to_almost_full();
    bus.mem_valid = 1'b1; bus.mem_reg = 3; bus.mem_data = 32'h33;
    bus.alu_valid = 1'b1; bus.alu_reg = 4; bus.alu_data = 32'h44;
    #1;
    checks++;
    if (bus.mem_ready !== 1'b1 || bus.alu_ready !== 1'b0) begin
      failures++;
      $display("FAIL prio_ready got=%b%b exp=10", bus.mem_ready, bus.alu_ready);
    end
    pos3 = -1; pos4 = -1;
    for (int t = 0; t < 20; t++) begin
      bit tm, ta;
      tm = bus.mem_valid && m_mem_ready();
      ta = bus.alu_valid && m_alu_ready();
      cycle();
      if (tm) bus.mem_valid = 1'b0;
      if (ta) bus.alu_valid = 1'b0;
      if (bus.signal_reg_write === 1'b1 && bus.write_reg === 3 && pos3 < 0) pos3 = t;
      if (bus.signal_reg_write === 1'b1 && bus.write_reg === 4 && pos4 < 0) pos4 = t;
    end
    checks++;
    if (pos3 < 0 || pos4 <= pos3) begin
      failures++; $display("FAIL prio_order got=%0d,%0d exp=3 before 4", pos3, pos4);
    end
  endtask

  task automatic test_zero_reg();
    drain();
    bus.alu_valid = 1'b1; bus.alu_reg = 0; bus.alu_data = 32'hFFFF_FFFF;
    #1;
    checks++;
    if (bus.alu_ready !== 1'b1) begin
      failures++; $display("FAIL zero_ready got=%b exp=1", bus.alu_ready);
    end
    cycle();
    idle();
    checks++;
    if (bus.q_empty !== 1'b1) begin
      failures++; $display("FAIL zero_empty got=%b exp=1", bus.q_empty);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bus.signal_reg_write !== 1'b0 || bus.busy_mask !== '0) begin
        failures++;
        $display("FAIL zero_nowrite got=%b/%h exp=0/0", bus.signal_reg_write, bus.busy_mask);
      end
      cycle();
    end
  endtask

  task automatic test_back_to_back();
    logic              got_wen [8];
    logic [ADDR_W-1:0] got_reg [8];
    int od;
`ifdef MIPS_WB_BYPASS_EN
    od = 0;
`else
    od = 1;
`endif
    drain();
    for (int k = 0; k < 8; k++) begin
      bus.mem_valid = 1'b0;
      bus.alu_valid = (k < 4);
      bus.alu_reg   = ADDR_W'(k + 1);
      bus.alu_data  = 32'(k + 100);
      #1;
      if (k < 4) begin
        checks++;
        if (bus.alu_ready !== m_alu_ready() || bus.q_full !== 1'b0) begin
          failures++;
          $display("FAIL b2b_ready k=%0d got=%b/%b exp=%b/0", k, bus.alu_ready, bus.q_full, m_alu_ready());
        end
      end
      cycle();
      got_wen[k] = bus.signal_reg_write;
      got_reg[k] = bus.write_reg;
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got_wen[od+i] !== 1'b1 || got_reg[od+i] !== ADDR_W'(i + 1)) begin
        failures++;
        $display("FAIL b2b_seq i=%0d got=%b/%0d exp=1/%0d", i, got_wen[od+i], got_reg[od+i], i + 1);
      end
    end
    checks++;
    if (got_wen[od+4] !== 1'b0) begin
      failures++; $display("FAIL b2b_tail got=%b exp=0", got_wen[od+4]);
    end
  endtask

  task automatic test_reset_flush();
    drain();
    fill_to_almost_full();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    checks++;
    if (bus.signal_reg_write !== 1'b0 || bus.q_empty !== 1'b1 || bus.busy_mask !== '0) begin
      failures++;
      $display("FAIL flush_state got=%b/%b/%h exp=0/1/0",
               bus.signal_reg_write, bus.q_empty, bus.busy_mask);
    end
    for (int k = 0; k < 6; k++) begin
      cycle();
      checks++;
      if (bus.signal_reg_write !== 1'b0) begin
        failures++; $display("FAIL flush_ghost k=%0d got=%b/%0d exp=0", k, bus.signal_reg_write, bus.write_reg);
      end
    end
  endtask

  task automatic test_bypass_mode();
    drain();
    bus.mem_valid = 1'b1; bus.mem_reg = 7; bus.mem_data = 32'hA5A5_A5A5;
    #1;
    checks++;
    if (bus.mem_ready !== 1'b1) begin
      failures++; $display("FAIL byp_ready got=%b exp=1", bus.mem_ready);
    end
    cycle();
    idle();
`ifdef MIPS_WB_BYPASS_EN
    checks++;
    if (bus.signal_reg_write !== 1'b1 || bus.write_reg !== 7 || bus.q_empty !== 1'b1) begin
      failures++;
      $display("FAIL byp_direct got=%b/%0d/%b exp=1/7/1", bus.signal_reg_write, bus.write_reg, bus.q_empty);
    end
`else
    checks++;
    if (bus.signal_reg_write !== 1'b0 || bus.q_empty !== 1'b0) begin
      failures++;
      $display("FAIL byp_queued got=%b/%b exp=0/0", bus.signal_reg_write, bus.q_empty);
    end
    cycle();
    checks++;
    if (bus.signal_reg_write !== 1'b1 || bus.write_reg !== 7 || bus.write_data !== 32'hA5A5_A5A5) begin
      failures++;
      $display("FAIL byp_write got=%b/%0d/%h exp=1/7/a5a5a5a5",
               bus.signal_reg_write, bus.write_reg, bus.write_data);
    end
`endif
  endtask

  task automatic test_random();
    drain();
    for (int n = 0; n < 600; n++) begin
      bit tm, ta;
      if (!bus.mem_valid && $urandom_range(0, 2) != 0) begin
        bus.mem_valid = 1'b1; bus.mem_reg = ADDR_W'($urandom_range(0, 7)); bus.mem_data = $urandom;
      end
      if (!bus.alu_valid && $urandom_range(0, 2) != 0) begin
        bus.alu_valid = 1'b1; bus.alu_reg = ADDR_W'($urandom_range(0, 7)); bus.alu_data = $urandom;
      end
      reset = ($urandom_range(0, 99) == 0);
      #1;
      checks++;
      if (bus.mem_ready !== m_mem_ready() || bus.alu_ready !== m_alu_ready()) begin
        failures++;
        $display("FAIL rnd_ready n=%0d got=%b%b exp=%b%b", n, bus.mem_ready, bus.alu_ready,
                 m_mem_ready(), m_alu_ready());
      end
      checks++;
      if (bus.signal_reg_write !== m_wen || bus.write_reg !== m_wreg || bus.write_data !== m_wdata) begin
        failures++;
        $display("FAIL rnd_write n=%0d got=%b/%0d/%h exp=%b/%0d/%h", n, bus.signal_reg_write,
                 bus.write_reg, bus.write_data, m_wen, m_wreg, m_wdata);
      end
      checks++;
      if (bus.busy_mask !== m_busy()) begin
        failures++; $display("FAIL rnd_busy n=%0d got=%h exp=%h", n, bus.busy_mask, m_busy());
      end
      checks++;
      if (bus.q_empty !== (m_reg.size() == 0) || bus.q_full !== (m_reg.size() == DEPTH)) begin
        failures++;
        $display("FAIL rnd_flags n=%0d got=%b%b exp=%b%b", n, bus.q_empty, bus.q_full,
                 m_reg.size() == 0, m_reg.size() == DEPTH);
      end
      tm = bus.mem_valid && m_mem_ready();
      ta = bus.alu_valid && m_alu_ready();
      cycle();
      if (tm) bus.mem_valid = 1'b0;
      if (ta) bus.alu_valid = 1'b0;
    end
    reset = 1'b0;
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.alu_valid = 1'b0; bus.alu_reg = '0; bus.alu_data = '0;
    bus.mem_valid = 1'b0; bus.mem_reg = '0; bus.mem_data = '0;
    test_reset();
    test_single_alu();
    test_priority();
    test_zero_reg();
    test_back_to_back();
    test_reset_flush();
    test_bypass_mode();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire
